bar_stream_fifo: RTL and testbench
==================================

// Module: bar_stream_fifo
// PURPOSE
//   Synchronous FIFO that buffers a 32-bit valid/ready stream (the bar interface's data/valid/ready fields).
//   It sits directly upstream of bar-interface consumers.
//   Its out_* side drives a consumer's x.data/x.valid and samples its x.ready.
//   It decouples producer and consumer stalls and absorbs up to DEPTH words.
// PARAMETERS
//   WIDTH  32  payload width; matches bar.data
//   DEPTH  4   storage entries; power of two, >= 2
// PORTS
//   clk        in   1             sole clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   in_data    in   WIDTH         upstream payload
//   in_valid   in   1             upstream word offered
//   in_ready   out  1             FIFO accepts a word this cycle
//   out_data   out  WIDTH         downstream payload (drives bar.data)
//   out_valid  out  1             word available (drives bar.valid)
//   out_ready  in   1             downstream accepts (from bar.ready)
//   count      out  $clog2(DEPTH)+1  occupancy; present only with BAR_STREAM_FIFO_COUNT_EN
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//   - Reset: while rst_n = 0, and immediately on its assertion:
//     - wr_ptr, rd_ptr and occupancy clear to 0.
//     - in_ready = 0, out_valid = 0, out_data = 0, count = 0.
//     - All storage entries clear to 0.
//   - After reset release: first rising edge with rst_n = 1 gives in_ready = 1.
//   - Reset mid-operation: all stored words are discarded. No partial transfer survives.
//   - Push and pop conditions:
//     - push = in_valid & in_ready.
//     - pop = out_valid & out_ready.
//     - Both are evaluated and take effect on the same rising edge.
//   - Ready and valid are registered flags:
//     - in_ready = !full.
//     - out_valid = !empty.
//     - Neither depends combinationally on in_valid or out_ready.
//   - Output is first-word-fall-through: out_data = mem[rd_ptr] whenever out_valid = 1.
//   - out_data while out_valid = 0:
//     - It shows mem[rd_ptr], i.e. stale data.
//     - Consumers must ignore it.
//     - It must be 0 after reset.
//   - Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. No same-cycle bypass.
//   - Occupancy update: occ_next = occ + push - pop, computed in $clog2(DEPTH)+1 bits.
//     - full = (occ == DEPTH).
//     - empty = (occ == 0).
//   - Pointers:
//     - $clog2(DEPTH) bits each.
//     - Increment on push (wr_ptr) and pop (rd_ptr).
//     - Wrap naturally from DEPTH-1 to 0.
//   - Boundary: full, with out_ready = 1.
//     - in_ready = 0, so there is no push that cycle.
//     - The pop frees a slot; in_ready rises after the edge.
//   - Boundary: empty, with in_valid = 1.
//     - out_valid = 0, so there is no pop.
//     - The push sets out_valid after the edge.
//   - Boundary: simultaneous push and pop when neither full nor empty.
//     - Occupancy is unchanged.
//     - Both pointers advance.
//   - Ordering: words leave in strict acceptance order. No loss and no duplication.
//   - Stall stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold stable.
//   - in_data is sampled only on a push edge.
// CONFIGURATION
//   BAR_STREAM_FIFO_COUNT_EN defined:
//     - Port count exists and equals the registered occupancy. Range 0..DEPTH.
//     - It updates on the same edge as the flags.
//   BAR_STREAM_FIFO_COUNT_EN undefined:
//     - Port count is absent.
//     - The occupancy register is still kept internally for full/empty.
//     - All other behaviour is identical.
// TESTING
//   1. Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, out_data=0.
//      After release, one edge later -> in_ready=1.
//   2. Single word: DEPTH=4, push 32'hDEADBEEF with out_ready=0 ->
//      next cycle out_valid=1, out_data=32'hDEADBEEF, count=1.
//      Raise out_ready for one cycle -> out_valid=0, count=0.
//   3. Fill and wrap: out_ready=0, push 1,2,3,4 -> in_ready=0 after 4th edge, count=4, 5th word not accepted.
//      Then out_ready=1 for 8 cycles while pushing 5..8 -> outputs in order 1..8.
//   4. Full with simultaneous offer: full, in_valid=1, out_ready=1 ->
//      that edge pops 1 and pushes nothing; count goes 4->3; in_ready=1 next cycle.
//   5. Streaming: in_valid=1 and out_ready=1 continuously, data 0..99 ->
//      after 1-cycle fill, one word per cycle out, all 100 in order, count stays 1.
//   6. Async reset mid-stream: assert rst_n=0 between edges with count=3 ->
//      out_valid drops immediately, no stale word emitted after release.

Source files
------------

// File: rtl/bar_stream_fifo.sv
// FWFT FIFO for a 32-bit valid/ready stream; push at edge N visible after N, no bypass; optional count port under BAR_STREAM_FIFO_COUNT_EN.
// Backpressure: in_ready/out_valid are registered (!full/!empty) and never combinational on in_valid/out_ready.
module bar_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef BAR_STREAM_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        occ_d       = occ_q + CW'(push) - CW'(pop);
        // Flags come from next occupancy so they settle on the same edge as count.
        in_ready_d  = (occ_d != CW'(DEPTH));
        out_valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_ptr_q];

`ifdef BAR_STREAM_FIFO_COUNT_EN
    assign count = occ_q;
`endif

endmodule

// File: tb/tb_bar_stream_fifo.sv
// Bench for bar_stream_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_bar_stream_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef BAR_STREAM_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;
`endif

    bar_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BAR_STREAM_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_in_ready  = 1'b0;
    logic             m_out_valid = 1'b0;
    logic [WIDTH-1:0] dut_out[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, flags registered from its size.
    always @(posedge clk or negedge rst_n) begin
        bit p, q;
        if (!rst_n) begin
            mq.delete();
            m_in_ready  = 1'b0;
            m_out_valid = 1'b0;
        end else begin
            p = in_valid && m_in_ready;
            q = m_out_valid && out_ready;
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(in_data);
            m_in_ready  = (mq.size() < DEPTH);
            m_out_valid = (mq.size() != 0);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid});
        if (!rst_n) chk("out_data_in_reset", out_data, 32'h0);
        else if (m_out_valid && mq.size() != 0) chk("out_data", out_data, mq[0]);
`ifdef BAR_STREAM_FIFO_COUNT_EN
        chk("count", 32'(count), 32'(mq.size()));
`endif
        if (rst_n && out_valid && out_ready) dut_out.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer words first..last, advancing only on accepted edges; caller sets out_ready.
    task automatic stream(input int first, input int last, input int budget);
        int nxt = first;
        int cyc = 0;
        bit acc;
        while ((nxt <= last || out_valid) && cyc < budget) begin
            if (nxt <= last) begin
                in_valid = 1'b1;
                in_data  = 32'(nxt);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) nxt++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_within_budget", {31'b0, cyc < budget}, 32'h1);
    endtask

    initial begin
        // 1. reset with in_valid held high
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("release_in_ready_before_edge", {31'b0, in_ready}, 32'h0);
        step();
        chk("release_in_ready_after_edge", {31'b0, in_ready}, 32'h1);

        // 2. single word
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        chk("single_out_valid", {31'b0, out_valid}, 32'h1);
        chk("single_out_data", out_data, 32'hDEADBEEF);
`ifdef BAR_STREAM_FIFO_COUNT_EN
        chk("single_count", 32'(count), 32'd1);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_drained", {31'b0, out_valid}, 32'h0);

        // 3. fill to full, fifth word refused
        dut_out.delete();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
        end
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        chk("full_head", out_data, 32'h1);
        in_data = 32'd5;
        step();
        chk("fifth_refused_in_ready", {31'b0, in_ready}, 32'h0);
        chk("fifth_refused_head", out_data, 32'h1);
`ifdef BAR_STREAM_FIFO_COUNT_EN
        chk("full_count", 32'(count), 32'd4);
`endif
        // 4. full with simultaneous offer: pop only
        out_ready = 1'b1;
        step();
        chk("full_pop_in_ready", {31'b0, in_ready}, 32'h1);
        chk("full_pop_head", out_data, 32'h2);
`ifdef BAR_STREAM_FIFO_COUNT_EN
        chk("full_pop_count", 32'(count), 32'd3);
`endif
        stream(5, 8, 40);
        out_ready = 1'b0;
        chk("wrap_len", 32'(dut_out.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < dut_out.size()) chk("wrap_order", dut_out[i], 32'(i + 1));

        // 5. continuous streaming
        dut_out.delete();
        out_ready = 1'b1;
        stream(0, 99, 300);
        chk("stream_len", 32'(dut_out.size()), 32'd100);
        for (int i = 0; i < 100; i++)
            if (i < dut_out.size()) chk("stream_order", dut_out[i], 32'(i));
        out_ready = 1'b0;

        // 6. async reset mid-stream with three words held
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hA0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
`ifdef BAR_STREAM_FIFO_COUNT_EN
        chk("pre_reset_count", 32'(count), 32'd3);
`endif
        chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_in_ready", {31'b0, in_ready}, 32'h0);
        chk("async_out_data", out_data, 32'h0);
        step();
        rst_n = 1'b1;
        dut_out.delete();
        out_ready = 1'b1;
        repeat (3) step();
        chk("no_stale_words", 32'(dut_out.size()), 32'd0);
        in_valid = 1'b1; in_data = 32'h00C0FFEE;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("post_reset_len", 32'(dut_out.size()), 32'd1);
        if (dut_out.size() != 0) chk("post_reset_word", dut_out[0], 32'h00C0FFEE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
